// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Fetch, data and memory-side signal bundle for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          flush_if;
   logic          if_valid;
   logic [DW-1:0] if_rdata;
   logic          stall_if;

   logic          dm_req;
   logic          dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic          dm_valid;
   logic [DW-1:0] dm_rdata;
   logic          stall_dm;

   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ready;
   logic [DW-1:0] mem_rdata;

   // Arbiter view
   modport slave (
      input  if_req, if_addr, flush_if, dm_req, dm_we, dm_addr, dm_wdata,
             mem_ready, mem_rdata,
      output if_valid, if_rdata, stall_if, dm_valid, dm_rdata, stall_dm,
             mem_req, mem_we, mem_addr, mem_wdata
   );

   // Pipeline plus memory view
   modport master (
      output if_req, if_addr, flush_if, dm_req, dm_we, dm_addr, dm_wdata,
             mem_ready, mem_rdata,
      input  if_valid, if_rdata, stall_if, dm_valid, dm_rdata, stall_dm,
             mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one single-port memory between fetch and data ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
   parameter int AW            = 32,
   parameter int DW            = 32,
   parameter int MAX_DM_STREAK = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   mem_port_arbiter_if.slave   bus
);
   localparam int                    c_STREAK_W   = $clog2(MAX_DM_STREAK + 1);
   localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(MAX_DM_STREAK);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_DM = 2'd2
   } state_t;

   state_t                r_state, w_nextState;
   logic [c_STREAK_W-1:0] r_streak, w_nextStreak;
   logic                  r_kill, w_nextKill;
   logic [AW-1:0]         r_addr;
   logic                  r_we;
   logic [DW-1:0]         r_wdata;
   logic [DW-1:0]         r_ifRdata;
   logic [DW-1:0]         r_dmRdata;

   logic w_ifPend, w_grantDm, w_grantIf, w_ifValid, w_dmValid;

   // A fetch being flushed this cycle is not a candidate for the grant
   assign w_ifPend  = bus.if_req && !bus.flush_if;
   assign w_grantDm = (r_state == IDLE) && bus.dm_req &&
                      (!w_ifPend || (r_streak < c_STREAK_MAX));
   assign w_grantIf = (r_state == IDLE) && w_ifPend && !w_grantDm;
   assign w_ifValid = (r_state == BUSY_IF) && bus.mem_ready && !r_kill && !bus.flush_if;
   assign w_dmValid = (r_state == BUSY_DM) && bus.mem_ready;

   always_comb begin
      w_nextState  = r_state;
      w_nextStreak = r_streak;
      w_nextKill   = r_kill;
      case (r_state)
         IDLE: begin
            w_nextKill = 1'b0;
            if (w_grantDm) begin
               w_nextState = BUSY_DM;
               if (!w_ifPend)
                  w_nextStreak = '0;
               else if (r_streak != c_STREAK_MAX)
                  w_nextStreak = r_streak + 1'b1;
            end else if (w_grantIf) begin
               w_nextState  = BUSY_IF;
               w_nextStreak = '0;
            end
         end
         BUSY_IF: begin
            if (bus.mem_ready) begin
               w_nextState = IDLE;
               w_nextKill  = 1'b0;
            end else if (bus.flush_if) begin
               w_nextKill = 1'b1;
            end
         end
         BUSY_DM: begin
            if (bus.mem_ready)
               w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
            w_nextKill  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_streak  <= '0;
         r_kill    <= 1'b0;
         r_addr    <= '0;
         r_we      <= 1'b0;
         r_wdata   <= '0;
         r_ifRdata <= '0;
         r_dmRdata <= '0;
      end else begin
         r_state  <= w_nextState;
         r_streak <= w_nextStreak;
         r_kill   <= w_nextKill;
         if (w_grantDm) begin
            r_addr  <= bus.dm_addr;
            r_we    <= bus.dm_we;
            r_wdata <= bus.dm_wdata;
         end else if (w_grantIf) begin
            r_addr <= bus.if_addr;
         end
         if (w_ifValid)
            r_ifRdata <= bus.mem_rdata;
         if (w_dmValid && !r_we)
            r_dmRdata <= bus.mem_rdata;
      end
   end

   // Memory side is driven purely from the latches while an access is open
   assign bus.mem_req   = (r_state != IDLE);
   assign bus.mem_we    = (r_state == BUSY_DM) && r_we;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;

   assign bus.if_valid  = w_ifValid;
   assign bus.if_rdata  = w_ifValid ? bus.mem_rdata : r_ifRdata;
   assign bus.stall_if  = bus.if_req && !w_ifValid && !bus.flush_if;

   assign bus.dm_valid  = w_dmValid;
   assign bus.dm_rdata  = (w_dmValid && !r_we) ? bus.mem_rdata : r_dmRdata;
   assign bus.stall_dm  = bus.dm_req && !w_dmValid;
endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Vector table, directed corner sequences and randomized model check.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;
   localparam int c_AW          = 32;
   localparam int c_DW          = 32;
   localparam int c_MAX         = 4;
   localparam int c_RAND_CYCLES = 400;
   localparam int c_NVEC        = 16;

   typedef struct packed {
      logic        memReq;
      logic        memWe;
      logic [31:0] memAddr;
      logic [31:0] memWdata;
      logic        ifValid;
      logic [31:0] ifRdata;
      logic        dmValid;
      logic [31:0] dmRdata;
      logic        stallIf;
      logic        stallDm;
   } outs_t;

   typedef struct {
      logic        ifReq;
      logic [31:0] ifAddr;
      logic        flush;
      logic        dmReq;
      logic        dmWe;
      logic [31:0] dmAddr;
      logic [31:0] dmWdata;
      logic        rdy;
      logic [31:0] rdata;
      outs_t       exp;
   } vec_t;

   logic clk;
   logic rst_n;
   int   nChecks = 0;
   int   nPass   = 0;
   vec_t tbl [c_NVEC];

   // Reference model: who currently owns the memory and what it latched
   int          mOwner;
   bit          mKilled;
   int          mStreak;
   logic [31:0] mAddr, mWdata, mIfR, mDmR;
   logic        mWe;

   mem_port_arbiter_if #(.AW(c_AW), .DW(c_DW)) bus ();

   mem_port_arbiter #(
      .AW(c_AW), .DW(c_DW), .MAX_DM_STREAK(c_MAX)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want run to finish");
      $fatal(1, "watchdog expired");
   end

   function automatic outs_t mko(input logic req, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic ifv, input logic [31:0] ifd,
                                 input logic dmv, input logic [31:0] dmd, input logic sti,
                                 input logic std);
      outs_t o;
      o.memReq = req;  o.memWe = we;    o.memAddr = addr; o.memWdata = wdata;
      o.ifValid = ifv; o.ifRdata = ifd; o.dmValid = dmv;  o.dmRdata = dmd;
      o.stallIf = sti; o.stallDm = std;
      return o;
   endfunction

   function automatic vec_t mkv(input logic ifReq, input logic [31:0] ifAddr, input logic flush,
                                input logic dmReq, input logic dmWe, input logic [31:0] dmAddr,
                                input logic [31:0] dmWdata, input logic rdy,
                                input logic [31:0] rdata, input outs_t exp);
      vec_t v;
      v.ifReq = ifReq; v.ifAddr = ifAddr; v.flush = flush; v.dmReq = dmReq; v.dmWe = dmWe;
      v.dmAddr = dmAddr; v.dmWdata = dmWdata; v.rdy = rdy; v.rdata = rdata; v.exp = exp;
      return v;
   endfunction

   function automatic outs_t snap();
      outs_t o;
      o.memReq = bus.mem_req;     o.memWe = bus.mem_we;
      o.memAddr = bus.mem_addr;   o.memWdata = bus.mem_wdata;
      o.ifValid = bus.if_valid;   o.ifRdata = bus.if_rdata;
      o.dmValid = bus.dm_valid;   o.dmRdata = bus.dm_rdata;
      o.stallIf = bus.stall_if;   o.stallDm = bus.stall_dm;
      return o;
   endfunction

   task automatic chkOuts(input string name, input outs_t exp);
      outs_t got;
      got = snap();
      nChecks++;
      if (got !== exp)
         $display("FAIL %s: got req=%b we=%b addr=%h wd=%h ifv=%b ifd=%h dmv=%b dmd=%h stall=%b%b, want req=%b we=%b addr=%h wd=%h ifv=%b ifd=%h dmv=%b dmd=%h stall=%b%b",
                  name, got.memReq, got.memWe, got.memAddr, got.memWdata, got.ifValid,
                  got.ifRdata, got.dmValid, got.dmRdata, got.stallIf, got.stallDm,
                  exp.memReq, exp.memWe, exp.memAddr, exp.memWdata, exp.ifValid,
                  exp.ifRdata, exp.dmValid, exp.dmRdata, exp.stallIf, exp.stallDm);
      else
         nPass++;
   endtask

   task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) $display("FAIL %s: got %h, want %h", name, got, exp);
      else             nPass++;
   endtask

   task automatic setIn(input logic ifReq, input logic [31:0] ifAddr, input logic flush,
                        input logic dmReq, input logic dmWe, input logic [31:0] dmAddr,
                        input logic [31:0] dmWdata, input logic rdy, input logic [31:0] rdata);
      bus.if_req = ifReq;  bus.if_addr = ifAddr;   bus.flush_if = flush;
      bus.dm_req = dmReq;  bus.dm_we = dmWe;       bus.dm_addr = dmAddr;
      bus.dm_wdata = dmWdata; bus.mem_ready = rdy; bus.mem_rdata = rdata;
   endtask

   // Inputs are applied just after a rising edge; outputs are sampled on the falling edge
   task automatic stepChk(input string name, input outs_t exp);
      @(negedge clk);
      chkOuts(name, exp);
      @(posedge clk);
      #1;
   endtask

   task automatic modelReset();
      mOwner = 0; mKilled = 0; mStreak = 0;
      mAddr = '0; mWdata = '0; mIfR = '0; mDmR = '0; mWe = 1'b0;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();
      @(posedge clk);
      #1;
   endtask

   function automatic outs_t modelOut();
      outs_t o;
      bit    done;
      done       = (mOwner != 0) && bus.mem_ready;
      o.memReq   = (mOwner != 0);
      o.memWe    = (mOwner == 2) && mWe;
      o.memAddr  = mAddr;
      o.memWdata = mWdata;
      o.ifValid  = (mOwner == 1) && done && !mKilled && !bus.flush_if;
      o.dmValid  = (mOwner == 2) && done;
      o.ifRdata  = o.ifValid ? bus.mem_rdata : mIfR;
      o.dmRdata  = (o.dmValid && !mWe) ? bus.mem_rdata : mDmR;
      o.stallIf  = bus.if_req && !o.ifValid && !bus.flush_if;
      o.stallDm  = bus.dm_req && !o.dmValid;
      return o;
   endfunction

   task automatic modelAdvance(input outs_t o);
      bit ifWants;
      ifWants = bus.if_req && !bus.flush_if;
      if (o.ifValid) mIfR = o.ifRdata;
      if (o.dmValid && !mWe) mDmR = o.dmRdata;
      if (mOwner == 0) begin
         if (bus.dm_req && (!ifWants || mStreak < c_MAX)) begin
            mOwner  = 2;
            mAddr   = bus.dm_addr;
            mWe     = bus.dm_we;
            mWdata  = bus.dm_wdata;
            mStreak = ifWants ? ((mStreak + 1 > c_MAX) ? c_MAX : mStreak + 1) : 0;
         end else if (ifWants) begin
            mOwner  = 1;
            mAddr   = bus.if_addr;
            mStreak = 0;
         end
      end else if (bus.mem_ready) begin
         mOwner  = 0;
         mKilled = 0;
      end else if (mOwner == 1 && bus.flush_if) begin
         mKilled = 1;
      end
   endtask

   task automatic runStarve();
      int          k;
      int          g;
      logic        prevReq;
      logic [31:0] expA [11];
      k = 0; g = 0; prevReq = 1'b0;
      doReset();
      for (int j = 0; j < 11; j++)
         expA[j] = (j == 4 || j == 9) ? 32'h500 :
                   32'h1000 + 32'(4 * (j - ((j > 9) ? 2 : ((j > 4) ? 1 : 0))));
      for (int cyc = 0; cyc < 100 && g < 11; cyc++) begin
         setIn(1, 32'h500, 0, 1, 0, 32'h1000 + 32'(4 * k), 0, 1, 32'hC0DE0000 + 32'(cyc));
         @(negedge clk);
         if (bus.mem_req && !prevReq) begin
            chk32($sformatf("starve_grant%0d", g), bus.mem_addr, expA[g]);
            g++;
         end
         prevReq = bus.mem_req;
         if (bus.dm_valid) k++;
         @(posedge clk);
         #1;
      end
      nChecks++;
      if (g == 11) nPass++;
      else $display("FAIL starve_grants: got %0d grants, want 11", g);
   endtask

   task automatic runFlush();
      doReset();
      setIn(1, 32'h80, 0, 0, 0, 0, 0, 0, 0);
      stepChk("flush_req",   mko(0, 0, 32'h0,  0, 0, 0, 0, 0, 1, 0));
      stepChk("flush_busy1", mko(1, 0, 32'h80, 0, 0, 0, 0, 0, 1, 0));
      setIn(1, 32'h80, 1, 0, 0, 0, 0, 0, 0);
      stepChk("flush_busy2", mko(1, 0, 32'h80, 0, 0, 0, 0, 0, 0, 0));
      setIn(1, 32'h90, 0, 0, 0, 0, 0, 0, 0);
      stepChk("flush_hold",  mko(1, 0, 32'h80, 0, 0, 0, 0, 0, 1, 0));
      setIn(1, 32'h90, 0, 0, 0, 0, 0, 1, 32'hAAAA5555);
      stepChk("flush_kill",  mko(1, 0, 32'h80, 0, 0, 0, 0, 0, 1, 0));
      setIn(1, 32'h90, 0, 0, 0, 0, 0, 0, 0);
      stepChk("flush_idle",  mko(0, 0, 32'h80, 0, 0, 0, 0, 0, 1, 0));
      setIn(1, 32'h90, 0, 0, 0, 0, 0, 1, 32'h900D0001);
      stepChk("flush_next",  mko(1, 0, 32'h90, 0, 1, 32'h900D0001, 0, 0, 0, 0));
      setIn(1, 32'hA0, 0, 0, 0, 0, 0, 0, 0);
      stepChk("flush2_req",  mko(0, 0, 32'h90, 0, 0, 32'h900D0001, 0, 0, 1, 0));
      setIn(1, 32'hA0, 1, 0, 0, 0, 0, 1, 32'h00000BAD);
      stepChk("flush2_same", mko(1, 0, 32'hA0, 0, 0, 32'h900D0001, 0, 0, 0, 0));
      setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
      stepChk("flush2_idle", mko(0, 0, 32'hA0, 0, 0, 32'h900D0001, 0, 0, 0, 0));
   endtask

   task automatic runResetSeq();
      doReset();
      setIn(0, 0, 0, 1, 0, 32'h300, 0, 0, 0);
      stepChk("rst_req", mko(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 1));
      @(negedge clk);
      chkOuts("rst_busy", mko(1, 0, 32'h300, 0, 0, 0, 0, 0, 0, 1));
      #2;
      rst_n = 1'b0;
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h77;
      #1;
      chkOuts("rst_async", mko(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 1));
      @(posedge clk);
      #1;
      chkOuts("rst_held", mko(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 1));
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      bus.mem_ready = 1'b0;
      #1;
      chkOuts("rst_release", mko(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 1));
      @(posedge clk);
      #1;
      setIn(0, 0, 0, 1, 0, 32'h300, 0, 0, 0);
      stepChk("rst_regrant", mko(1, 0, 32'h300, 0, 0, 0, 0, 0, 0, 1));
      setIn(0, 0, 0, 1, 0, 32'h300, 0, 1, 32'h3003);
      stepChk("rst_done",    mko(1, 0, 32'h300, 0, 0, 0, 1, 32'h3003, 0, 0));
      setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
      stepChk("rst_after",   mko(0, 0, 32'h300, 0, 0, 0, 0, 32'h3003, 0, 0));
   endtask

   task automatic runRandom();
      outs_t exp;
      bit    lastIfV, lastDmV, lastFl;
      lastIfV = 0; lastDmV = 0; lastFl = 0;
      doReset();
      for (int c = 0; c < c_RAND_CYCLES; c++) begin
         if (!(bus.if_req && !lastIfV && !lastFl)) begin
            bus.if_req  = 1'($urandom_range(0, 1));
            bus.if_addr = $urandom & 32'hFFFF_FFFC;
         end
         bus.flush_if = ($urandom_range(0, 11) == 0);
         if (bus.dm_req && !lastDmV) begin
            if ($urandom_range(0, 19) == 0) bus.dm_req = 1'b0;
         end else begin
            bus.dm_req   = ($urandom_range(0, 2) != 0);
            bus.dm_we    = 1'($urandom_range(0, 1));
            bus.dm_addr  = $urandom & 32'hFFFF_FFFC;
            bus.dm_wdata = $urandom;
         end
         bus.mem_ready = ($urandom_range(0, 9) < 4);
         bus.mem_rdata = $urandom;
         @(negedge clk);
         exp = modelOut();
         chkOuts($sformatf("rand%0d", c), exp);
         modelAdvance(exp);
         lastIfV = exp.ifValid;
         lastDmV = exp.dmValid;
         lastFl  = bus.flush_if;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      tbl[0]  = mkv(0, 0,      0, 0, 0, 0,      0,            0, 0,            mko(0, 0, 32'h0,   0,            0, 0,            0, 0,            0, 0));
      tbl[1]  = mkv(1, 32'h40, 0, 0, 0, 0,      0,            0, 0,            mko(0, 0, 32'h0,   0,            0, 0,            0, 0,            1, 0));
      tbl[2]  = mkv(1, 32'h40, 0, 0, 0, 0,      0,            1, 32'h00500093, mko(1, 0, 32'h40,  0,            1, 32'h00500093, 0, 0,            0, 0));
      tbl[3]  = mkv(0, 0,      0, 0, 0, 0,      0,            0, 0,            mko(0, 0, 32'h40,  0,            0, 32'h00500093, 0, 0,            0, 0));
      tbl[4]  = mkv(1, 32'h44, 0, 1, 0, 32'h100, 0,           0, 0,            mko(0, 0, 32'h40,  0,            0, 32'h00500093, 0, 0,            1, 1));
      tbl[5]  = mkv(1, 32'h44, 0, 1, 0, 32'h100, 0,           0, 0,            mko(1, 0, 32'h100, 0,            0, 32'h00500093, 0, 0,            1, 1));
      tbl[6]  = mkv(1, 32'h44, 0, 1, 0, 32'h100, 0,           0, 32'hCAFE0000, mko(1, 0, 32'h100, 0,            0, 32'h00500093, 0, 0,            1, 1));
      tbl[7]  = mkv(1, 32'h44, 0, 1, 0, 32'h100, 0,           1, 32'hDEADBEEF, mko(1, 0, 32'h100, 0,            0, 32'h00500093, 1, 32'hDEADBEEF, 1, 0));
      tbl[8]  = mkv(1, 32'h44, 0, 0, 0, 0,      0,            0, 0,            mko(0, 0, 32'h100, 0,            0, 32'h00500093, 0, 32'hDEADBEEF, 1, 0));
      tbl[9]  = mkv(1, 32'h44, 0, 0, 0, 0,      0,            1, 32'h11111111, mko(1, 0, 32'h44,  0,            1, 32'h11111111, 0, 32'hDEADBEEF, 0, 0));
      tbl[10] = mkv(0, 0,      0, 0, 0, 0,      0,            0, 0,            mko(0, 0, 32'h44,  0,            0, 32'h11111111, 0, 32'hDEADBEEF, 0, 0));
      tbl[11] = mkv(0, 0,      0, 1, 1, 32'h200, 32'h12345678, 0, 0,           mko(0, 0, 32'h44,  0,            0, 32'h11111111, 0, 32'hDEADBEEF, 0, 1));
      tbl[12] = mkv(0, 0,      0, 1, 1, 32'h300, 32'hFFFF0000, 0, 0,           mko(1, 1, 32'h200, 32'h12345678, 0, 32'h11111111, 0, 32'hDEADBEEF, 0, 1));
      tbl[13] = mkv(0, 0,      0, 0, 0, 32'h300, 0,           0, 0,            mko(1, 1, 32'h200, 32'h12345678, 0, 32'h11111111, 0, 32'hDEADBEEF, 0, 0));
      tbl[14] = mkv(0, 0,      0, 0, 0, 0,      0,            1, 32'h00000BAD, mko(1, 1, 32'h200, 32'h12345678, 0, 32'h11111111, 1, 32'hDEADBEEF, 0, 0));
      tbl[15] = mkv(0, 0,      0, 0, 0, 0,      0,            1, 32'h00005555, mko(0, 0, 32'h200, 32'h12345678, 0, 32'h11111111, 0, 32'hDEADBEEF, 0, 0));

      rst_n = 1'b0;
      setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chkOuts("reset_state", mko(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0));
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < c_NVEC; i++) begin
         setIn(tbl[i].ifReq, tbl[i].ifAddr, tbl[i].flush, tbl[i].dmReq, tbl[i].dmWe,
               tbl[i].dmAddr, tbl[i].dmWdata, tbl[i].rdy, tbl[i].rdata);
         stepChk($sformatf("vec%0d", i), tbl[i].exp);
      end

      runStarve();
      runFlush();
      runResetSeq();
      runRandom();

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end
endmodule

`default_nettype wire
